tdm_slot_capture: RTL and testbench

- Receive-side counterpart of the rotating channel selector: one serial line carries NUM_CH channel levels in turn, with the slot advancing on each change_flag.
- Block tracks the same slot sequence, waits for the line to settle, takes a majority-voted sample per slot and holds each channel's level on its own output bit.
- Sits on the input side of the scan-signal interface, feeding per-channel status to downstream logic.

---
 rtl/tdm_slot_capture.sv | 118 +++++++++++
 tb/tb_tdm_slot_capture.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/tdm_slot_capture.sv
// Receive side of a time-multiplexed status line: follows the transmitter's slot
// rotation, lets the line settle, majority-votes a few samples and holds one level per channel.
module tdm_slot_capture #(
    parameter int NUM_CH  = 5,
    parameter int SETTLE  = 4,
    parameter int SAMPLES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              change_flag,
    input  logic              frame_sync,
    input  logic              data_in,
    output logic [NUM_CH-1:0] data_out,
    output logic              ch_valid,
    output logic [2:0]        ch_idx,
    output logic              frame_done,
    output logic              slot_abort,
    output logic [15:0]       abort_cnt
);

    localparam int CNT_MAX = (SETTLE > SAMPLES) ? SETTLE : SAMPLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int OW      = $clog2(SAMPLES + 1);

    typedef enum logic [1:0] {
        ST_SETTLE,
        ST_SAMPLE,
        ST_HOLD
    } state_t;

    state_t        state;
    logic [2:0]    slot;
    logic [2:0]    slot_next;
    logic          sync1;
    logic          d_s;
    logic [CW-1:0] cnt;
    logic [OW-1:0] ones;
    logic          slot_event;
    logic          vote;

    assign slot_event = frame_sync | change_flag;
    assign ch_idx     = slot;

    // Majority: twice the count of ones exceeds the sample count.
    assign vote = ({1'b0, ones} << 1) > (OW + 1)'(SAMPLES);

    always_comb begin
        slot_next = slot;
        if (frame_sync) begin
            slot_next = 3'd0;
        end else if (change_flag) begin
            slot_next = (slot == 3'(NUM_CH - 1)) ? 3'd0 : slot + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_SETTLE;
            slot       <= 3'd0;
            sync1      <= 1'b0;
            d_s        <= 1'b0;
            cnt        <= '0;
            ones       <= '0;
            data_out   <= '0;
            ch_valid   <= 1'b0;
            frame_done <= 1'b0;
            slot_abort <= 1'b0;
            abort_cnt  <= 16'd0;
        end else begin
            sync1      <= data_in;
            d_s        <= sync1;
            ch_valid   <= 1'b0;
            frame_done <= 1'b0;
            slot_abort <= 1'b0;
            if (slot_event) begin
                slot  <= slot_next;
                state <= ST_SETTLE;
                cnt   <= '0;
                ones  <= '0;
                // A slot that never reached its decision is discarded and counted.
                if (state != ST_HOLD) begin
                    slot_abort <= 1'b1;
                    if (abort_cnt != 16'hFFFF) begin
                        abort_cnt <= abort_cnt + 16'd1;
                    end
                end
            end else begin
                case (state)
                    ST_SETTLE: begin
                        if (cnt == CW'(SETTLE - 1)) begin
                            state <= ST_SAMPLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_SAMPLE: begin
                        if (cnt == CW'(SAMPLES)) begin
                            for (int i = 0; i < NUM_CH; i++) begin
                                if (slot == 3'(i)) begin
                                    data_out[i] <= vote;
                                end
                            end
                            ch_valid   <= 1'b1;
                            frame_done <= (slot == 3'(NUM_CH - 1));
                            state      <= ST_HOLD;
                        end else begin
                            ones <= ones + OW'(d_s);
                            cnt  <= cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_slot_capture.sv
// Randomised and directed bench for tdm_slot_capture, checked every cycle against a
// slot-age model of the receiver.
module tb_tdm_slot_capture;

    localparam int NUM_CH  = 5;
    localparam int SETTLE  = 4;
    localparam int SAMPLES = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              change_flag = 1'b0;
    logic              frame_sync = 1'b0;
    logic              data_in = 1'b1;
    logic [NUM_CH-1:0] data_out;
    logic              ch_valid;
    logic [2:0]        ch_idx;
    logic              frame_done;
    logic              slot_abort;
    logic [15:0]       abort_cnt;

    tdm_slot_capture #(.NUM_CH(NUM_CH), .SETTLE(SETTLE), .SAMPLES(SAMPLES)) dut (
        .clk(clk), .rst_n(rst_n), .change_flag(change_flag), .frame_sync(frame_sync),
        .data_in(data_in), .data_out(data_out), .ch_valid(ch_valid), .ch_idx(ch_idx),
        .frame_done(frame_done), .slot_abort(slot_abort), .abort_cnt(abort_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: slot number, cycles since the last slot event, and whether it was decided.
    int              m_slot, m_age, m_ones, m_abort;
    bit              m_done, m_s1, m_s2;
    logic [NUM_CH-1:0] m_data;
    bit              e_valid, e_fd, e_ab;

    int cyc, first_valid, n_valid, n_abort, fd4, last_idx;

    task automatic model_reset();
        m_slot = 0; m_age = 0; m_ones = 0; m_abort = 0; m_done = 0;
        m_s1 = 0; m_s2 = 0; m_data = '0;
        e_valid = 0; e_fd = 0; e_ab = 0;
    endtask

    task automatic model_edge(input bit cf, input bit fs, input bit din);
        bit ds;
        ds = m_s2; m_s2 = m_s1; m_s1 = din;
        e_valid = 0; e_fd = 0; e_ab = 0;
        if (cf || fs) begin
            if (!m_done) begin
                e_ab = 1;
                if (m_abort < 65535) m_abort++;
            end
            m_slot = fs ? 0 : (m_slot + 1) % NUM_CH;
            m_age = 0; m_ones = 0; m_done = 0;
        end else if (!m_done) begin
            m_age++;
            if (m_age >= SETTLE + 1 && m_age <= SETTLE + SAMPLES) begin
                m_ones += int'(ds);
            end else if (m_age == SETTLE + SAMPLES + 1) begin
                m_data[m_slot] = (2 * m_ones > SAMPLES);
                e_valid = 1;
                e_fd = (m_slot == NUM_CH - 1);
                m_done = 1;
            end
        end
    endtask

    task automatic compare();
        checks++;
        if (data_out !== m_data || ch_valid !== e_valid || ch_idx !== 3'(m_slot) ||
            frame_done !== e_fd || slot_abort !== e_ab || abort_cnt !== 16'(m_abort)) begin
            failures++;
            $display("FAIL cycle_compare cyc=%0d got data=%b v=%b idx=%0d fd=%b ab=%b cnt=%0d exp data=%b v=%b idx=%0d fd=%b ab=%b cnt=%0d",
                     cyc, data_out, ch_valid, ch_idx, frame_done, slot_abort, abort_cnt,
                     m_data, e_valid, m_slot, e_fd, e_ab, m_abort);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    // Called at a falling edge: drive, let one rising edge pass, check, return at next falling edge.
    task automatic step(input bit cf, input bit fs, input bit din);
        change_flag = cf; frame_sync = fs; data_in = din;
        @(posedge clk);
        model_edge(cf, fs, din);
        cyc++;
        #1;
        compare();
        if (ch_valid) begin
            n_valid++;
            last_idx = int'(ch_idx);
            if (first_valid < 0) first_valid = cyc;
            if (frame_done && ch_idx == 3'd4) fd4++;
        end
        if (slot_abort) n_abort++;
        @(negedge clk);
    endtask

    task automatic slot_run(input bit cf, input bit fs, input bit din, input int len);
        step(cf, fs, din);
        for (int k = 1; k < len; k++) step(1'b0, 1'b0, din);
    endtask

    initial begin
        logic [NUM_CH-1:0] d0;
        int a0;
        bit pat [5] = '{1, 0, 1, 1, 0};
        bit din_r;

        model_reset();
        cyc = 0; first_valid = -1; n_valid = 0; n_abort = 0; fd4 = 0; last_idx = -1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_data_out", int'(data_out), 0);
        chk("reset_abort_cnt", int'(abort_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Slot 0 captured after reset with no change_flag.
        for (int k = 0; k < 12; k++) step(1'b0, 1'b0, 1'b1);
        chk("first_valid_cycle", first_valid, SETTLE + SAMPLES + 1);
        chk("first_data_out", int'(data_out), 5'b00001);
        chk("first_valid_count", n_valid, 1);
        chk("first_no_frame_done", fd4, 0);

        // Full rotation at a 12-cycle pitch.
        for (int s = 1; s < NUM_CH; s++) slot_run(1'b1, 1'b0, pat[s], 12);
        chk("rotation_data_out", int'(data_out), 5'b01101);
        chk("frame_done_at_idx4", fd4, 1);
        step(1'b1, 1'b0, 1'b1);
        chk("wrap_to_slot0", int'(ch_idx), 0);
        for (int k = 1; k < 12; k++) step(1'b0, 1'b0, 1'b1);

        // Slot 2: two of three samples low, then a single-sample glitch low.
        slot_run(1'b0, 1'b1, 1'b1, 12);
        slot_run(1'b1, 1'b0, 1'b0, 12);
        step(1'b1, 1'b0, 1'b1);
        for (int k = 1; k < 12; k++) step(1'b0, 1'b0, (k == 3 || k == 4) ? 1'b0 : 1'b1);
        chk("two_low_samples", int'(data_out[2]), 0);
        slot_run(1'b0, 1'b1, 1'b1, 12);
        slot_run(1'b1, 1'b0, 1'b0, 12);
        step(1'b1, 1'b0, 1'b1);
        for (int k = 1; k < 12; k++) step(1'b0, 1'b0, (k == 4) ? 1'b0 : 1'b1);
        chk("glitch_rejected", int'(data_out[2]), 1);

        // Slot events every 6 cycles: all but the first (leaving HOLD) abort.
        d0 = data_out; a0 = int'(abort_cnt); n_abort = 0;
        for (int e = 0; e < 6; e++) begin
            step(1'b1, 1'b0, 1'($urandom_range(0, 1)));
            for (int k = 1; k < 6; k++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
        end
        chk("abort_pulses", n_abort, 5);
        chk("abort_cnt_delta", int'(abort_cnt) - a0, 5);
        chk("abort_data_kept", int'(data_out), int'(d0));
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b1);

        // Steer to slot 3, then frame_sync together with change_flag.
        for (int i = 0; i < 8 && m_slot != 3; i++) slot_run(1'b1, 1'b0, 1'b1, 12);
        chk("steered_slot3", int'(ch_idx), 3);
        n_valid = 0;
        slot_run(1'b1, 1'b1, 1'b0, 12);
        chk("sync_priority_idx", last_idx, 0);
        chk("sync_priority_valid", n_valid, 1);
        a0 = int'(abort_cnt); n_valid = 0; last_idx = -1;
        slot_run(1'b0, 1'b1, 1'b1, 12);
        chk("sync_hold_recapture", last_idx, 0);
        chk("sync_hold_no_abort", int'(abort_cnt) - a0, 0);

        // Fill all ones, then reset mid-sample of slot 3.
        slot_run(1'b0, 1'b1, 1'b1, 12);
        for (int s = 1; s < NUM_CH; s++) slot_run(1'b1, 1'b0, 1'b1, 12);
        chk("all_ones", int'(data_out), 5'b11111);
        for (int s = 0; s < 3; s++) slot_run(1'b1, 1'b0, 1'b1, 12);
        slot_run(1'b1, 1'b0, 1'b1, 7);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'({data_out, ch_valid, ch_idx, frame_done, slot_abort}), 0);
        chk("async_reset_abort_cnt", int'(abort_cnt), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        n_valid = 0; last_idx = -1;
        for (int k = 0; k < 12; k++) step(1'b0, 1'b0, 1'b1);
        chk("restart_idx", last_idx, 0);
        chk("restart_valid_count", n_valid, 1);

        // Random soak: sparse events, slowly varying line.
        din_r = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 5) == 0) din_r = ~din_r;
            step($urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0, din_r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
